switch_debouncer: RTL and testbench

- Input-side conditioner for the board slide switches and push buttons that feed the gate and LED logic.
- Per bit, it synchronises the raw asynchronous switch inputs into the clk domain and debounces them with a stability counter.
- Outputs: clean levels plus single-cycle rise/fall event pulses.
- Sits between the board pins and every consumer of switch values.

---
 rtl/switch_debouncer.sv | 83 ++++++++
 tb/tb_switch_debouncer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Per-bit synchroniser + stability-counter debouncer with rise/fall pulses.
// Optional latching toggle output enabled by SWITCH_DB_TOGGLE_EN.
module switch_debouncer #(
    parameter int N           = 2,
    parameter int CNT_MAX     = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] switch,
    output logic [N-1:0] switch_db,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
`ifdef SWITCH_DB_TOGGLE_EN
    ,
    output logic [N-1:0] toggle
`endif
);

    localparam int CW = $clog2(CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic [SYNC_STAGES-1:0] chain;
        logic                   sync;
        logic [CW-1:0]          cnt;
        logic                   db_q;
        logic                   rise_q;
        logic                   fall_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                chain <= '0;
            end else begin
                chain <= {chain[SYNC_STAGES-2:0], switch[i]};
            end
        end

        assign sync = chain[SYNC_STAGES-1];

        // Any cycle agreeing with the accepted level restarts the count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt    <= '0;
                db_q   <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sync == db_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt    <= '0;
                    db_q   <= sync;
                    rise_q <= sync;
                    fall_q <= ~sync;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign switch_db[i] = db_q;
        assign rise[i]      = rise_q;
        assign fall[i]      = fall_q;

`ifdef SWITCH_DB_TOGGLE_EN
        logic tog_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tog_q <= 1'b0;
            end else if (rise_q) begin
                tog_q <= ~tog_q;
            end
        end

        assign toggle[i] = tog_q;
`endif
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Table-driven, scoreboarded bench for switch_debouncer (N=2, CNT_MAX=4).
// Toggle checks compile in when SWITCH_DB_TOGGLE_EN is defined.
module tb_switch_debouncer;

    typedef struct {
        logic [1:0] sw;
        logic [1:0] db;
        logic [1:0] r;
        logic [1:0] f;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [1:0] switch;
    logic [1:0] switch_db;
    logic [1:0] rise;
    logic [1:0] fall;
`ifdef SWITCH_DB_TOGGLE_EN
    logic [1:0] toggle;
`endif

    int   n_tests;
    int   n_fail;
    int   cyc;
    vec_t tbl[$];
    vec_t sb[$];
    int   mark;

    switch_debouncer #(
        .N(2),
        .CNT_MAX(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .switch(switch),
        .switch_db(switch_db),
        .rise(rise),
        .fall(fall)
`ifdef SWITCH_DB_TOGGLE_EN
        ,
        .toggle(toggle)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic [1:0] sw, input logic [1:0] db,
                                input logic [1:0] r, input logic [1:0] f,
                                input int n);
        vec_t v;
        v.sw = sw;
        v.db = db;
        v.r  = r;
        v.f  = f;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    task automatic check(input string name, input vec_t e);
        n_tests++;
        if (switch_db !== e.db || rise !== e.r || fall !== e.f) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got db=%b r=%b f=%b, want db=%b r=%b f=%b",
                     name, cyc, switch_db, rise, fall, e.db, e.r, e.f);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        vec_t e;
        for (int k = lo; k < hi; k++) begin
            switch = tbl[k].sw;
            sb.push_back(tbl[k]);
            @(posedge clk);
            #1;
            cyc++;
            e = sb.pop_front();
            check($sformatf("vec%0d", k), e);
        end
    endtask

`ifdef SWITCH_DB_TOGGLE_EN
    task automatic hold_tog(input logic [1:0] sw, input logic [1:0] want);
        switch = sw;
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (toggle !== want) begin
            n_fail++;
            $display("FAIL toggle sw=%b: got %b, want %b", sw, toggle, want);
        end
    endtask
`endif

    initial begin
        vec_t z;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        z.sw = 2'b11;
        z.db = 2'b00;
        z.r  = 2'b00;
        z.f  = 2'b00;

        // Power-on level already high: accepted through normal debounce.
        add(2'b11, 2'b00, 2'b00, 2'b00, 5);
        add(2'b11, 2'b11, 2'b11, 2'b00, 1);
        add(2'b11, 2'b11, 2'b00, 2'b00, 1);
        add(2'b00, 2'b11, 2'b00, 2'b00, 5);
        add(2'b00, 2'b00, 2'b00, 2'b11, 1);
        add(2'b00, 2'b00, 2'b00, 2'b00, 1);
        // Clean step on bit 0
        add(2'b01, 2'b00, 2'b00, 2'b00, 5);
        add(2'b01, 2'b01, 2'b01, 2'b00, 1);
        add(2'b01, 2'b01, 2'b00, 2'b00, 2);
        add(2'b11, 2'b01, 2'b00, 2'b00, 5);
        add(2'b11, 2'b11, 2'b10, 2'b00, 1);
        add(2'b11, 2'b11, 2'b00, 2'b00, 1);
        // Falling edge on bit 1
        add(2'b01, 2'b11, 2'b00, 2'b00, 5);
        add(2'b01, 2'b01, 2'b00, 2'b10, 1);
        add(2'b01, 2'b01, 2'b00, 2'b00, 1);
        add(2'b00, 2'b01, 2'b00, 2'b00, 5);
        add(2'b00, 2'b00, 2'b00, 2'b01, 1);
        add(2'b00, 2'b00, 2'b00, 2'b00, 1);
        // Bounce on bit 0
        add(2'b01, 2'b00, 2'b00, 2'b00, 2);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2);
        add(2'b01, 2'b00, 2'b00, 2'b00, 2);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2);
        add(2'b01, 2'b00, 2'b00, 2'b00, 5);
        add(2'b01, 2'b01, 2'b01, 2'b00, 1);
        add(2'b01, 2'b01, 2'b00, 2'b00, 1);
        // Bit 1 rising, interrupted by async reset
        add(2'b11, 2'b01, 2'b00, 2'b00, 3);
        mark = tbl.size();
        add(2'b11, 2'b00, 2'b00, 2'b00, 5);
        add(2'b11, 2'b11, 2'b11, 2'b00, 1);
        add(2'b11, 2'b11, 2'b00, 2'b00, 1);

        rst    = 1'b1;
        switch = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset%0d", k), z);
        end
        rst = 1'b0;

        run_vecs(0, mark);

        // Async clear between edges, no clock involved
        #1;
        rst = 1'b1;
        #1;
        check("async_clr", z);
        #1;
        rst = 1'b0;

        run_vecs(mark, tbl.size());

`ifdef SWITCH_DB_TOGGLE_EN
        @(posedge clk);
        #1;
        rst = 1'b1;
        switch = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if (toggle !== 2'b00) begin
            n_fail++;
            $display("FAIL toggle_reset: got %b, want 00", toggle);
        end
        hold_tog(2'b01, 2'b01);
        hold_tog(2'b00, 2'b01);
        hold_tog(2'b01, 2'b00);
        hold_tog(2'b00, 2'b00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
